// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Multi-cycle control FSM for the simple RV32I core. Sequences
//            FETCH / DECODE / EXEC / MEM / WB over a shared datapath with a
//            single ALU and a single memory port, and handshakes with memory.
// Ports    : clk, rst (async, active-high)
//            instr[31:0]           IR contents (valid from DECODE onward)
//            mem_ready             memory completed the current request
//            branch_cond           datapath branch comparison result
//            mem_req, mem_we       memory request / store qualifier
//            ir_we, pc_we, pc_sel  IR load, PC update, PC source select
//            alu_op, alu_f7_5      controls into alu_control
//            alu_src_b             ALU operand B select (0 rs2, 1 imm)
//            reg_we, wb_sel        register write enable / writeback source
//            illegal               sticky illegal-opcode flag
//            state[2:0]            current FSM state (debug)
// Options  : define CTRL_PERF_EN to add cycle_cnt / instret_cnt counters
//            (width CNT_W).
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        branch_cond,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [1:0]  alu_op,
    output logic        alu_f7_5,
    output logic        alu_src_b,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic [2:0]  state
`ifdef CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("multicycle_ctrl: CNT_W must be at least 1");
    end

    state_t      r_state;
    state_t      w_next_state;
    logic        r_illegal;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_is_r, w_is_i, w_is_load, w_is_store;
    logic        w_is_branch, w_is_lui, w_is_jal, w_is_legal;
    logic [1:0]  w_dec_alu_op;
    logic        w_dec_src_b;
    logic        w_dec_f7_5;
    logic        w_unused_instr;

    assign w_opcode    = instr[6:0];
    assign w_funct3    = instr[14:12];
    assign w_is_r      = (w_opcode == OP_R);
    assign w_is_i      = (w_opcode == OP_I_ALU);
    assign w_is_load   = (w_opcode == OP_LOAD);
    assign w_is_store  = (w_opcode == OP_STORE);
    assign w_is_branch = (w_opcode == OP_BRANCH);
    assign w_is_lui    = (w_opcode == OP_LUI);
    assign w_is_jal    = (w_opcode == OP_JAL);
    assign w_is_legal  = w_is_r | w_is_i | w_is_load | w_is_store |
                         w_is_branch | w_is_lui | w_is_jal;

    // Register/immediate fields are consumed by the datapath, not here.
    assign w_unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    // ALU control decode. instr[30] is only a real funct7 bit for R-type and
    // the shift-right immediates; elsewhere it is immediate data and must not
    // turn e.g. ADDI with a negative immediate into SUB.
    always_comb begin
        w_dec_alu_op = 2'b00;
        w_dec_src_b  = 1'b1;
        w_dec_f7_5   = 1'b0;
        if (w_is_r) begin
            w_dec_alu_op = 2'b10;
            w_dec_src_b  = 1'b0;
            w_dec_f7_5   = instr[30];
        end else if (w_is_i) begin
            w_dec_alu_op = 2'b10;
            w_dec_f7_5   = (w_funct3 == 3'b101) ? instr[30] : 1'b0;
        end else if (w_is_branch) begin
            w_dec_alu_op = 2'b01;
            w_dec_src_b  = 1'b0;
        end else if (w_is_lui) begin
            w_dec_alu_op = 2'b11;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state == S_HALT) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // Outputs are gated by rst so that an asynchronous reset drops any held
    // memory request in the same cycle, not at the next edge.
    always_comb begin
        w_next_state = r_state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 2'b10;
        alu_op       = 2'b00;
        alu_f7_5     = 1'b0;
        alu_src_b    = 1'b0;
        reg_we       = 1'b0;
        wb_sel       = 2'b00;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we        = 1'b1;
                        pc_we        = 1'b1;
                        pc_sel       = 2'b00;
                        w_next_state = S_DECODE;
                    end
                end
                S_DECODE: begin
                    w_next_state = w_is_legal ? S_EXEC : S_HALT;
                end
                S_EXEC: begin
                    alu_op    = w_dec_alu_op;
                    alu_f7_5  = w_dec_f7_5;
                    alu_src_b = w_dec_src_b;
                    if (w_is_load || w_is_store) begin
                        w_next_state = S_MEM;
                    end else if (w_is_branch) begin
                        pc_we        = branch_cond;
                        pc_sel       = 2'b01;
                        w_next_state = S_FETCH;
                    end else if (w_is_jal) begin
                        // Link value PC+4 comes from the datapath's PC-old copy.
                        pc_we        = 1'b1;
                        pc_sel       = 2'b01;
                        reg_we       = 1'b1;
                        wb_sel       = 2'b10;
                        w_next_state = S_FETCH;
                    end else if (w_is_r || w_is_i || w_is_lui) begin
                        w_next_state = S_WB;
                    end else begin
                        w_next_state = S_HALT;
                    end
                end
                S_MEM: begin
                    // ALU controls stay applied so the address stays stable.
                    alu_op    = w_dec_alu_op;
                    alu_f7_5  = w_dec_f7_5;
                    alu_src_b = w_dec_src_b;
                    mem_req   = 1'b1;
                    mem_we    = w_is_store;
                    if (mem_ready) begin
                        w_next_state = w_is_load ? S_WB : S_FETCH;
                    end
                end
                S_WB: begin
                    alu_op       = w_dec_alu_op;
                    alu_f7_5     = w_dec_f7_5;
                    alu_src_b    = w_dec_src_b;
                    reg_we       = 1'b1;
                    wb_sel       = w_is_load ? 2'b01 : 2'b00;
                    w_next_state = S_FETCH;
                end
                S_HALT: begin
                    w_next_state = S_HALT;
                end
                default: begin
                    w_next_state = S_HALT;
                end
            endcase
        end
    end

    assign illegal = r_illegal;
    assign state   = r_state;

`ifdef CTRL_PERF_EN
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instret_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if (r_state != S_HALT) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            end
            // An instruction retires when control returns to FETCH.
            if ((w_next_state == S_FETCH) &&
                ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB))) begin
                r_instret_cnt <= r_instret_cnt + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the simple RV32I core. Sequences fetch/decode/execute/memory/writeback over the shared datapath (single ALU, single memory port). Drives alu_op and a qualified funct7_5 into alu_control, plus all datapath enables, and handshakes with the memory port.

Parameters:
CNT_W, 32, width of the performance counters (used only with CTRL_PERF_EN).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
instr  input  32  current IR contents from datapath (valid from DECODE onward)
mem_ready  input  1  memory port completed the current request this cycle
branch_cond  input  1  datapath comparison result for the current branch (funct3 evaluated in datapath)
mem_req  output  1  memory access request, held until mem_ready
mem_we  output  1  write strobe qualifier for mem_req (stores only)
ir_we  output  1  load IR from memory read data
pc_we  output  1  update PC this cycle
pc_sel  output  2  00 PC+4, 01 PC+imm (branch/JAL), 10 hold
alu_op  output  2  to alu_control: 00 ADD, 01 SUB, 10 funct decode, 11 LUI
alu_f7_5  output  1  qualified funct7_5 to alu_control
alu_src_b  output  1  0 rs2, 1 immediate
reg_we  output  1  register-file write enable
wb_sel  output  2  00 ALU result, 01 memory data, 10 PC+4
illegal  output  1  sticky illegal-opcode flag
state  output  3  current FSM state for debug

Behaviour:
- Reset (async, immediate): state=FETCH, illegal=0, all strobes (mem_req, mem_we, ir_we, pc_we, reg_we)=0, pc_sel=10, alu_op=00, alu_f7_5=0, alu_src_b=0, wb_sel=00. First FETCH begins on the first edge after rst deasserts.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7. All outputs decoded combinationally from state and instr; strobes are 1-cycle pulses unless stated.
- FETCH: mem_req=1, mem_we=0, held while mem_ready=0. On mem_ready=1: ir_we=1, pc_we=1, pc_sel=00, next DECODE.
- DECODE: opcode=instr[6:0]. Legal: 0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 0110111 LUI, 1101111 JAL. Legal -> EXEC. Any other -> HALT, illegal set.
- EXEC alu_op/alu_src_b: R 10/0; I-ALU 10/1; LOAD, STORE 00/1; BRANCH 01/0; LUI 11/1; JAL 00/1.
- alu_f7_5 = instr[30] when R-type, or I-ALU with funct3=101 (SRLI/SRAI); else 0. Keeps ADDI with negative immediate from decoding as SUB.
- EXEC next state: R, I-ALU, LUI -> WB. LOAD, STORE -> MEM. BRANCH: pc_we=branch_cond, pc_sel=01, -> FETCH. JAL: pc_sel=01, pc_we=1, reg_we=1, wb_sel=10, -> FETCH. PC+4 for JAL is taken from the PC-old copy in the datapath.
- MEM: mem_req=1, mem_we=1 for STORE, address from ALU result. Held until mem_ready. On mem_ready: LOAD -> WB, STORE -> FETCH.
- WB: reg_we=1. wb_sel=01 for LOAD, else 00. Next state FETCH.
- Latency with zero-wait memory: R/I/LUI 4 cycles; LOAD 5; STORE 4; BRANCH/JAL 3. Each mem_ready=0 cycle adds 1.
- mem_ready while mem_req=0 is ignored.
- HALT: all strobes 0, illegal=1, remains until rst.
- Reset during a held mem_req drops mem_req immediately and returns to FETCH.
- Unused state encodings (5, 6) go to HALT with illegal=1.

Optional Feature:
CTRL_PERF_EN: when defined, adds outputs cycle_cnt[CNT_W-1:0] and instret_cnt[CNT_W-1:0], both reset to 0.
- cycle_cnt increments every cycle outside HALT.
- instret_cnt increments on each transition into FETCH from EXEC, MEM or WB.
- Both counters wrap modulo 2^CNT_W.
When not defined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready=1 -> states 0,1,2,4,0; alu_op=10, alu_f7_5=0 in EXEC; reg_we=1 only in WB, wb_sel=00.
- sub 0x402081B3 -> alu_f7_5=1 in EXEC. addi x1,x0,-1 (0xFFF00093) -> alu_op=10, alu_src_b=1, alu_f7_5=0. srai (0x4030D093) -> alu_f7_5=1.
- lw (0x0000A103), mem_ready low 3 cycles in MEM -> mem_req=1 for 4 cycles with mem_we=0, then WB with wb_sel=01 and reg_we=1. Total 8 cycles.
- beq (0x00208463): branch_cond=1 -> EXEC alu_op=01, pc_we=1, pc_sel=01, next FETCH. branch_cond=0 -> pc_we=0.
- instr=0x00000000 -> DECODE to HALT, illegal=1, no strobes for 10 cycles. Assert rst -> FETCH, illegal=0.
- rst asserted mid-MEM of sw (0x0020A023) with mem_ready=0 -> mem_req=0 immediately, state=0. With CTRL_PERF_EN, both counters read 0.
